// File: rtl/stream_cmp_stats.sv
`default_nettype none
// ============================================================================
// Module   : stream_cmp_stats
// Purpose  : Per-frame threshold compare statistics (lt/eq/gt counts, min/max)
// Revision : 1.0
// ============================================================================
module stream_cmp_stats #(
  parameter int W  = 4,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          thr_wr,
  input  logic [W-1:0]  thr_in,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_min,
  output logic [W-1:0]  out_max,
  output logic [CW-1:0] out_cnt_lt,
  output logic [CW-1:0] out_cnt_eq,
  output logic [CW-1:0] out_cnt_gt,
  output logic          out_ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [CW-1:0] c_cnt_max = '1;

  state_t        state_q, state_d;
  logic [W-1:0]  thr_q, thr_d;
  logic [W-1:0]  min_q, min_d;
  logic [W-1:0]  max_q, max_d;
  logic [CW-1:0] cnt_lt_q, cnt_lt_d;
  logic [CW-1:0] cnt_eq_q, cnt_eq_d;
  logic [CW-1:0] cnt_gt_q, cnt_gt_d;
  logic          ovf_q, ovf_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  logic w_accept;
  logic w_first;

  assign w_accept = in_valid && in_ready_q;
  assign w_first  = (state_q == S_IDLE);

  always_comb begin
    state_d  = state_q;
    thr_d    = thr_q;
    min_d    = min_q;
    max_d    = max_q;
    cnt_lt_d = cnt_lt_q;
    cnt_eq_d = cnt_eq_q;
    cnt_gt_d = cnt_gt_q;
    ovf_d    = ovf_q;

    // Threshold only changes between frames; compares below use the old value.
    if (w_first && thr_wr) begin
      thr_d = thr_in;
    end

    if (w_accept) begin
      if (w_first) begin
        min_d    = in_data;
        max_d    = in_data;
        cnt_lt_d = '0;
        cnt_eq_d = '0;
        cnt_gt_d = '0;
        ovf_d    = 1'b0;
      end else begin
        if (in_data < min_q) min_d = in_data;
        if (in_data > max_q) max_d = in_data;
      end

      if (in_data < thr_q) begin
        if (cnt_lt_d == c_cnt_max) ovf_d = 1'b1;
        else                       cnt_lt_d = cnt_lt_d + 1'b1;
      end else if (in_data == thr_q) begin
        if (cnt_eq_d == c_cnt_max) ovf_d = 1'b1;
        else                       cnt_eq_d = cnt_eq_d + 1'b1;
      end else begin
        if (cnt_gt_d == c_cnt_max) ovf_d = 1'b1;
        else                       cnt_gt_d = cnt_gt_d + 1'b1;
      end

      state_d = in_last ? S_HOLD : S_ACCUM;
    end

    if (state_q == S_HOLD && out_ready) begin
      state_d = S_IDLE;
    end
  end

  // Handshake outputs are registered copies of the next state.
  assign in_ready_d  = (state_d != S_HOLD);
  assign out_valid_d = (state_d == S_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      thr_q       <= '0;
      min_q       <= '0;
      max_q       <= '0;
      cnt_lt_q    <= '0;
      cnt_eq_q    <= '0;
      cnt_gt_q    <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      thr_q       <= thr_d;
      min_q       <= min_d;
      max_q       <= max_d;
      cnt_lt_q    <= cnt_lt_d;
      cnt_eq_q    <= cnt_eq_d;
      cnt_gt_q    <= cnt_gt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_min    = min_q;
  assign out_max    = max_q;
  assign out_cnt_lt = cnt_lt_q;
  assign out_cnt_eq = cnt_eq_q;
  assign out_cnt_gt = cnt_gt_q;
  assign out_ovf    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_cmp_stats.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_cmp_stats
// Purpose  : Directed self-checking bench for stream_cmp_stats
// Revision : 1.0
// ============================================================================
module tb_stream_cmp_stats;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       thr_wr;
  logic [3:0] thr_in;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_min;
  logic [3:0] out_max;
  logic [3:0] out_cnt_lt;
  logic [3:0] out_cnt_eq;
  logic [3:0] out_cnt_gt;
  logic       out_ovf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stream_cmp_stats #(.W(4), .CW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .thr_wr     (thr_wr),
    .thr_in     (thr_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_min    (out_min),
    .out_max    (out_max),
    .out_cnt_lt (out_cnt_lt),
    .out_cnt_eq (out_cnt_eq),
    .out_cnt_gt (out_cnt_gt),
    .out_ovf    (out_ovf)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic write_thr(input logic [3:0] t);
    thr_wr = 1'b1;
    thr_in = t;
    tick();
    thr_wr = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [3:0] mn, input logic [3:0] mx,
                              input logic [3:0] lt, input logic [3:0] eq,
                              input logic [3:0] gt, input logic ovf);
    check({tag, "_valid"}, {7'd0, out_valid}, 8'd1);
    check({tag, "_ready"}, {7'd0, in_ready}, 8'd0);
    check({tag, "_min"}, {4'd0, out_min}, {4'd0, mn});
    check({tag, "_max"}, {4'd0, out_max}, {4'd0, mx});
    check({tag, "_lt"}, {4'd0, out_cnt_lt}, {4'd0, lt});
    check({tag, "_eq"}, {4'd0, out_cnt_eq}, {4'd0, eq});
    check({tag, "_gt"}, {4'd0, out_cnt_gt}, {4'd0, gt});
    check({tag, "_ovf"}, {7'd0, out_ovf}, {7'd0, ovf});
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, {7'd0, out_valid}, 8'd0);
    check({tag, "_ready"}, {7'd0, in_ready}, 8'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    thr_wr    = 1'b0;
    thr_in    = 4'd0;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    #12;
    rst_n = 1'b1;
    tick();
    check_idle("rst");
    check("rst_ovf", {7'd0, out_ovf}, 8'd0);

    // Basic frame, thr=5: 3,5,9,5,12
    write_thr(4'd5);
    send(4'd3, 1'b0);
    send(4'd5, 1'b0);
    send(4'd9, 1'b0);
    send(4'd5, 1'b0);
    send(4'd12, 1'b1);
    check_result("basic", 4'd3, 4'd12, 4'd1, 4'd2, 4'd2, 1'b0);
    tick();
    check_idle("basic_rel");

    // Single-sample frame, thr=0
    write_thr(4'd0);
    send(4'd0, 1'b1);
    check_result("single", 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 1'b0);
    tick();
    check_idle("single_rel");

    // Backpressure with a rejected sample offered during HOLD
    out_ready = 1'b0;
    send(4'd2, 1'b0);
    send(4'd7, 1'b1);
    in_valid = 1'b1;
    in_data  = 4'd1;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_result("bp", 4'd2, 4'd7, 4'd0, 4'd0, 4'd2, 1'b0);
      tick();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    check_result("bp_last", 4'd2, 4'd7, 4'd0, 4'd0, 4'd2, 1'b0);
    tick();
    check_idle("bp_rel");
    send(4'd4, 1'b1);
    check_result("bp_next", 4'd4, 4'd4, 4'd0, 4'd0, 4'd1, 1'b0);
    tick();

    // Saturation: 17 zeros then a last zero against thr=15
    write_thr(4'd15);
    for (int i = 0; i < 17; i++) send(4'd0, 1'b0);
    send(4'd0, 1'b1);
    check_result("sat", 4'd0, 4'd0, 4'd15, 4'd0, 4'd0, 1'b1);
    tick();
    send(4'd15, 1'b1);
    check_result("sat_next", 4'd15, 4'd15, 4'd0, 4'd1, 4'd0, 1'b0);
    tick();

    // Threshold write during ACCUM is ignored (thr stays 5)
    write_thr(4'd5);
    send(4'd5, 1'b0);
    thr_wr = 1'b1;
    thr_in = 4'd8;
    send(4'd8, 1'b0);
    thr_wr = 1'b0;
    send(4'd8, 1'b1);
    check_result("thr_accum", 4'd5, 4'd8, 4'd0, 4'd1, 4'd2, 1'b0);
    tick();

    // Threshold write coincident with first sample: first 8 vs old thr 0
    write_thr(4'd0);
    thr_wr = 1'b1;
    thr_in = 4'd8;
    send(4'd8, 1'b0);
    thr_wr = 1'b0;
    send(4'd8, 1'b0);
    send(4'd8, 1'b1);
    check_result("thr_coinc", 4'd8, 4'd8, 4'd0, 4'd2, 4'd1, 1'b0);
    tick();

    // Reset mid-ACCUM clears threshold (currently 8)
    send(4'd3, 1'b0);
    rst_n = 1'b0;
    #2;
    check("rstacc_valid", {7'd0, out_valid}, 8'd0);
    rst_n = 1'b1;
    tick();
    check_idle("rstacc_rel");
    send(4'd0, 1'b0);
    send(4'd1, 1'b1);
    check_result("rstacc_next", 4'd0, 4'd1, 4'd0, 4'd1, 4'd1, 1'b0);

    // Reset during HOLD drops out_valid without a clock edge
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rsthold_valid", {7'd0, out_valid}, 8'd0);
    check("rsthold_ready", {7'd0, in_ready}, 8'd1);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check_idle("rsthold_rel");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_cmp_stats.md
Name: stream_cmp_stats

Overview:
- Sequential stage directly downstream of the 4-bit magnitude comparator.
- Accepts a framed stream of unsigned samples via a valid/ready handshake.
- Compares each sample against a programmable threshold and tracks the frame's min/max.
- On frame end, presents per-frame less/equal/greater counts plus min/max via an output valid/ready handshake.

Parameters:
- W, 4, sample and threshold width (unsigned).
- CW, 4, per-category counter width; counters saturate at 2^CW-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- thr_wr  input  1  threshold write strobe.
- thr_in  input  W  threshold value.
- in_valid  input  1  sample valid.
- in_ready  output  1  stage can accept a sample.
- in_data  input  W  sample.
- in_last  input  1  sample is the last of its frame.
- out_valid  output  1  frame result valid.
- out_ready  input  1  consumer accepts the result.
- out_min  output  W  minimum sample of the frame.
- out_max  output  W  maximum sample of the frame.
- out_cnt_lt  output  CW  count of samples < threshold.
- out_cnt_eq  output  CW  count of samples == threshold.
- out_cnt_gt  output  CW  count of samples > threshold.
- out_ovf  output  1  one or more counters saturated during the frame.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, threshold=0, all counters=0, min=max=0.
  - out_valid=0, out_ovf=0, in_ready=1 once reset is released.
- Accept condition: in_valid && in_ready, sampled on the clk rising edge.
- in_ready: in_ready = (state != HOLD), registered from state; no combinational path from out_ready.
- FSM states:
  - IDLE: no frame in progress.
    - Accept with in_last=0 -> ACCUM.
    - Accept with in_last=1 -> HOLD (single-sample frame).
  - ACCUM: frame in progress.
    - Accept with in_last=0 -> stay in ACCUM.
    - Accept with in_last=1 -> HOLD.
  - HOLD: out_valid=1.
    - out_ready=1 -> IDLE on that edge.
    - Otherwise stay; all outputs held stable.
- Per accepted sample:
  - First sample of a frame (state IDLE): loads min=max=sample.
  - Later samples: min=sample if sample<min; max=sample if sample>max.
  - Exactly one of lt/eq/gt increments, chosen by an unsigned compare against the current threshold.
  - The increment is suppressed at 2^CW-1 and sets the sticky ovf flag.
  - In IDLE, counters and ovf first clear, then the first sample's increment applies (i.e. that category loads 1).
- Latency: out_valid rises on the edge that accepts the last sample, so outputs are visible the following cycle and include that sample.
- Output registers: out_* are the accumulating registers themselves.
  - They are meaningful only while out_valid=1.
  - They are not cleared on leaving HOLD; the next frame's first sample overwrites them.
- Throughput: one sample per cycle in IDLE/ACCUM. HOLD blocks input, so at least one bubble separates frames.
- Threshold:
  - thr_wr is honoured only in IDLE, taking effect for samples accepted from the next cycle.
  - thr_wr in ACCUM/HOLD is ignored.
  - thr_wr coincident with the first accepted sample in IDLE: that sample compares against the old threshold.
- Boundaries:
  - in_valid=0 mid-frame: stay in ACCUM, registers unchanged.
  - in_last is ignored when in_valid=0.
  - Sample equal to both min and max (constant frame): min=max=value.
  - Reset asserted mid-frame or in HOLD: the frame is discarded immediately, out_valid drops asynchronously, state=IDLE.

Test Plan:
- Reset check: W=4, CW=4. Assert rst_n=0 mid-ACCUM -> out_valid=0, in_ready=1 after release, threshold reads back as 0 on the next frame's compares.
- Basic frame: thr=5; send 3,5,9,5,12(last); out_ready=1 -> out_valid 1 cycle after 12 accepted; min=3, max=12, lt=1, eq=2, gt=2, ovf=0; return to IDLE.
- Single-sample frame: thr=0; send 0 with last -> min=max=0, lt=0, eq=1, gt=0.
- Backpressure: hold out_ready=0 for 5 cycles after a frame -> in_ready=0 and outputs stable throughout. Then raise out_ready -> out_valid falls and in_ready rises next cycle; the next frame's first sample starts the counts fresh.
- Saturation: thr=15; send 17 samples of 0 then last -> lt=15, eq=0, gt=0, ovf=1. The next frame of one sample 15 gives eq=1, ovf=0.
- Threshold gating:
  - thr_wr=1, thr_in=8 during ACCUM -> ignored; samples still compare against the previous value.
  - thr_wr in IDLE coincident with the first sample 8 (old thr=0) -> that sample counts gt. Subsequent 8s in the frame count eq.
